// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage plus IF/ID pipeline register for the RV32I core
//
// Purpose: generates fetch addresses and drives a single-outstanding,
// variable-latency instruction-memory handshake. Applies EX redirects and
// hazard-unit stalls/flushes. Holds one returned instruction while decode is
// stalled.
//
// Ports:
//   clk, rst             core clock, synchronous active-high reset
//   stallF, stallD       active-low stalls (1 = PC / IF/ID may advance)
//   flushD               1 = IF/ID becomes a bubble
//   pc_sel, pc_target    EX-stage redirect
//   imem_req, imem_addr  fetch request and address
//   imem_ready           response valid; completes the request
//   imem_rdata           fetched instruction
//   PC_D, PCplus4_D      IF/ID PC and PC+4
//   Instr_D, valid_D     IF/ID instruction, 1 = real fetched instruction
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pc_sel,
  input  logic [31:0] pc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_D,
  output logic [31:0] PCplus4_D,
  output logic [31:0] Instr_D,
  output logic        valid_D
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_KILL} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pcp4_q, id_pcp4_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;

  logic        adv;
  logic        deliver;
  logic [31:0] dlv_pc;
  logic [31:0] dlv_instr;

  assign adv = stallF & stallD;

  always_comb begin
    state_d     = state_q;
    pc_f_d      = pc_f_q;
    req_addr_d  = req_addr_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    imem_req    = 1'b0;
    imem_addr   = req_addr_q;
    deliver     = 1'b0;
    dlv_pc      = req_addr_q;
    dlv_instr   = imem_rdata;

    case (state_q)
      S_FETCH: begin
        imem_req   = 1'b1;
        imem_addr  = pc_f_q;
        // Remember the issued address so a kill can keep presenting it.
        req_addr_d = pc_f_q;
        if (imem_ready) begin
          if (pc_sel) begin
            pc_f_d = pc_target;
          end else if (adv) begin
            deliver = 1'b1;
            dlv_pc  = pc_f_q;
            pc_f_d  = pc_f_q + 32'd4;
          end else begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = pc_f_q;
            state_d     = S_HOLD;
          end
        end else if (pc_sel) begin
          pc_f_d  = pc_target;
          state_d = S_KILL;
        end
      end
      S_HOLD: begin
        if (pc_sel) begin
          pc_f_d  = pc_target;
          state_d = S_FETCH;
        end else if (adv) begin
          deliver   = 1'b1;
          dlv_pc    = buf_pc_q;
          dlv_instr = buf_instr_q;
          pc_f_d    = buf_pc_q + 32'd4;
          state_d   = S_FETCH;
        end
      end
      S_KILL: begin
        // The stale request must complete before a new one may issue.
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
        if (pc_sel) begin
          pc_f_d = pc_target;
        end
        if (imem_ready) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    if (rst) begin
      imem_req = 1'b0;
    end
  end

  // IF/ID: flush beats stall; an advancing slot with nothing to deliver
  // takes a bubble.
  always_comb begin
    id_pc_d    = id_pc_q;
    id_pcp4_d  = id_pcp4_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    if (flushD || (stallD && !deliver)) begin
      id_pc_d    = 32'd0;
      id_pcp4_d  = 32'd0;
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end else if (stallD) begin
      id_pc_d    = dlv_pc;
      id_pcp4_d  = dlv_pc + 32'd4;
      id_instr_d = dlv_instr;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_f_q      <= RESET_PC;
      req_addr_q  <= RESET_PC;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= 32'd0;
      id_pc_q     <= 32'd0;
      id_pcp4_q   <= 32'd0;
      id_instr_q  <= NOP_INSTR;
      id_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_f_q      <= pc_f_d;
      req_addr_q  <= req_addr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      id_pc_q     <= id_pc_d;
      id_pcp4_q   <= id_pcp4_d;
      id_instr_q  <= id_instr_d;
      id_valid_q  <= id_valid_d;
    end
  end

  assign PC_D      = id_pc_q;
  assign PCplus4_D = id_pcp4_q;
  assign Instr_D   = id_instr_q;
  assign valid_D   = id_valid_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage RV32I core; sits directly upstream of decode.
- Consumes hazard-unit outputs stallF, stallD, flushD and EX-stage redirect pc_sel/pc_target.
- Drives a single-outstanding, variable-latency instruction-memory handshake.
- Holds at most one returned instruction when decode is stalled.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID on flush or empty slot.

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
stallF  input  1  from hazard unit; 1 = PC may advance, 0 = hold PC (active-low stall).
stallD  input  1  from hazard unit; 1 = IF/ID may load, 0 = hold IF/ID (active-low stall).
flushD  input  1  from hazard unit; 1 = replace IF/ID contents with bubble.
pc_sel  input  1  EX-stage redirect (taken branch/jump).
pc_target  input  32  redirect address, valid when pc_sel=1.
imem_req  output  1  fetch request.
imem_addr  output  32  fetch address; stable while imem_req=1 until accepted.
imem_ready  input  1  1 = imem_rdata valid this cycle; completes the request.
imem_rdata  input  32  fetched instruction.
PC_D  output  32  IF/ID PC.
PCplus4_D  output  32  IF/ID PC+4.
Instr_D  output  32  IF/ID instruction.
valid_D  output  1  1 = Instr_D is a real fetched instruction.

Behaviour:
- Internal state: PC_F (next fetch PC), req_addr (address of in-flight request), buf_instr/buf_pc (1-entry hold buffer), FSM state.
- Advance condition: adv = stallF & stallD.
- Reset (rst=1, highest priority): PC_F=RESET_PC, state=FETCH, PC_D=0, PCplus4_D=0, Instr_D=NOP_INSTR, valid_D=0.
  - imem_req is forced 0 while rst=1.
  - First request (addr=RESET_PC) is issued in the first cycle after rst deasserts.
- FSM states:
  - FETCH: imem_req=1, imem_addr=req_addr (=PC_F at issue).
    - ready & pc_sel: discard data; PC_F<=pc_target; stay FETCH.
    - ready & !pc_sel & adv: IF/ID<={req_addr, req_addr+4, imem_rdata, valid=1}; PC_F<=req_addr+4; new request issues next cycle.
    - ready & !pc_sel & !adv: capture into buffer; go HOLD.
    - !ready & pc_sel: PC_F<=pc_target; go KILL. imem_addr stays unchanged.
    - !ready & !pc_sel: remain FETCH. If stallD=1, IF/ID loads a bubble (NOP_INSTR, valid_D=0).
  - HOLD: imem_req=0.
    - pc_sel: drop buffer; PC_F<=pc_target; go FETCH.
    - adv: IF/ID<=buffer (valid=1); PC_F<=buf_pc+4; go FETCH.
    - else: stay HOLD.
  - KILL: imem_req=1 with the old req_addr until imem_ready; the returned data is discarded; then go FETCH using PC_F.
    - A further pc_sel in KILL overwrites PC_F with the newest target.
- Priority:
  - PC: rst > pc_sel > stallF.
  - IF/ID: rst > flushD > stallD. When flushD=1, IF/ID becomes NOP_INSTR, valid_D=0, PC_D/PCplus4_D=0, even if stallD=0.
- Redirect latency: the first instruction from pc_target reaches IF/ID no earlier than 2 cycles after pc_sel with zero-wait imem.
- With zero-wait imem and no hazards: one instruction per cycle; valid_D stays 1 continuously.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0 with no error.
- At most one outstanding request; imem_addr never changes while imem_req=1 and imem_ready=0.
- Reset mid-request (any state): return to reset values; any in-flight response arriving after reset is ignored.

Test Plan:
- Reset then zero-wait imem returning addr-tagged words, adv=1 -> Instr_D sequence for PCs 0,4,8,C; valid_D=1 every cycle starting the 2nd cycle after rst deasserts.
- Hold stallF=stallD=0 for 3 cycles with the response ready at PC=8 -> imem_req drops; IF/ID unchanged; on release Instr_D for PC 8 appears, then PC C requested.
- imem_ready delayed 3 cycles, pc_sel=1, pc_target=0x100 in wait cycle 1 -> imem_addr stays 0x4 until ready; data discarded; next imem_addr=0x100.
- pc_sel with pc_target=0x40 in the same cycle as ready -> data dropped; next request 0x40; flushD=1 -> valid_D=0, Instr_D=0x00000013.
- flushD=1 together with stallD=0 -> IF/ID cleared to a bubble (flush wins).
- RESET_PC=0xFFFFFFFC, run 2 fetches -> imem_addr sequence FFFFFFFC then 00000000; PCplus4_D=0.
